ram_sdp_be: RTL and testbench
=============================

Name: ram_sdp_be

Overview:
Parametrised simple-dual-port RAM with one write port and one read port.
- Adds per-byte write enables and a configurable read latency of 1 or 2 cycles.
- Read-during-write collision behaviour is selectable.
- An optional post-reset hardware clear sweep zeroes the array.
- Serves as the general-purpose on-chip buffer for datapath blocks that previously used the single-port bidirectional-bus RAM; separate din/dout ports remove the tri-state bus.

Parameters:
DATA_WIDE, 32, data word width in bits; must be a multiple of BYTE_WIDE.
BYTE_WIDE, 8, width of one byte lane.
DEEP, 512, number of words; any value >= 2, not required to be a power of 2.
ADDR_WIDE, $clog2(DEEP), address width.
RD_LAT, 1, read latency in cycles; legal values 1 or 2 only, other values are an elaboration error.
RDW_MODE, 0, same-address read-during-write result: 0 = read-first (old data), 1 = write-first (merged new data).
INIT_CLR, 1, 1 = clear all words to 0 after reset; 0 = no clear, memory content undefined.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_WIDE  write address
wr_be  input  DATA_WIDE/BYTE_WIDE  byte enables; bit i covers wr_data[i*BYTE_WIDE +: BYTE_WIDE]
wr_data  input  DATA_WIDE  write data
rd_en  input  1  read request
rd_addr  input  ADDR_WIDE  read address
rd_data  output  DATA_WIDE  read data, registered
rd_valid  output  1  one-cycle pulse marking rd_data valid
oor_err  output  1  one-cycle pulse: an accepted request had an address >= DEEP
init_done  output  1  high once the RAM accepts requests

Behaviour:
Reset (asynchronous, active-low; clock clk):
- rd_data = 0, rd_valid = 0, oor_err = 0.
- Clear counter = 0.
- With INIT_CLR=1: state = CLEAR, init_done = 0.
- With INIT_CLR=0: state = READY, init_done = 1.
- The memory array itself is not reset.

Control FSM (states CLEAR, READY):
- CLEAR: each posedge writes 0 to word[clr_cnt] and increments clr_cnt.
- The posedge that writes word DEEP-1 moves the FSM to READY and sets init_done = 1.
- init_done therefore rises on the DEEP-th posedge after rst_n deasserts.
- In CLEAR, wr_en and rd_en are ignored: no writes, rd_valid stays 0, oor_err stays 0.
- READY is terminal until the next reset.
- Reset asserted mid-CLEAR restarts the sweep from address 0.

Write (READY only):
- wr_en=1 and wr_addr<DEEP: each byte lane with wr_be[i]=1 is updated at the posedge; other lanes keep their value.
- wr_be all zero is a no-op and is not an error.
- wr_addr>=DEEP: write dropped; oor_err=1 on the next cycle.

Read (READY only):
- rd_en=1 samples rd_addr at posedge T.
- RD_LAT=1: rd_data is updated and rd_valid=1 after posedge T+1 (visible in cycle T+1).
- RD_LAT=2: one further output register stage; data visible in cycle T+2.
- Back-to-back reads every cycle give full throughput, with one rd_valid pulse per request in order.
- rd_data holds its last value while rd_valid=0.
- rd_addr>=DEEP: rd_data=0 with rd_valid=1 at normal latency; oor_err pulses in the same cycle as that rd_valid.

Collision (wr_en & rd_en, same in-range address, same cycle):
- RDW_MODE=0: read returns the pre-write word.
- RDW_MODE=1: read returns wr_data on enabled lanes and old data on disabled lanes.
- The write always completes.
- Different addresses: no interaction.

oor_err when both ports are out of range in the same cycle:
- RD_LAT=1: the write-side and read-side pulses coincide and merge into a single pulse.
- RD_LAT=2: two separate pulses (write side next cycle, read side with rd_valid).

Decomposition:
Package ram_pkg holds:
- typedef enum logic {CLEAR, READY} ram_state_e
- typedef enum bit {RD_FIRST=0, WR_FIRST=1} rdw_mode_e
- localparam function nbytes(DATA_WIDE, BYTE_WIDE)

One sub-module, ram_clr_fsm, contains:
- the CLEAR/READY state
- clr_cnt
- init_done
- clear-write address/enable outputs, muxed onto the write port

Memory array, byte-lane write loop, collision merge and latency pipeline stay in ram_sdp_be.

Test Plan:
Test values: DATA_WIDE=32, DEEP=512, INIT_CLR=1.
1. Release rst_n; count posedges -> init_done rises on posedge 512; wr_en=1 to addr 5 with data 0xDEADBEEF during CLEAR is ignored; reading addr 5 after init returns 0x00000000.
2. Write 0x11223344 be=4'hF at addr 132, then 0xAABBCCDD be=4'b0101 at addr 132; read 132 -> 0x11BB33DD, rd_valid exactly 1 cycle after rd_en (RD_LAT=1), 2 cycles with RD_LAT=2.
3. Same-cycle write 0x55555555 be=4'hF and read at addr 133, holding old value 0x00000001 -> RDW_MODE=0 returns 0x00000001, RDW_MODE=1 returns 0x55555555; a following read returns 0x55555555 in both modes.
4. Run with DEEP=500: read addr 511 -> rd_data=0, rd_valid=1, oor_err=1 in the same cycle; write addr 510 -> oor_err pulse next cycle, no array word changes.
5. Eight back-to-back reads of addrs 0..7 after writing value = addr*3 -> eight consecutive rd_valid pulses returning 0,3,6,...,21 in order at RD_LAT=1 and RD_LAT=2.
6. Assert rst_n low at posedge 200 of CLEAR, release -> init_done low again, rises 512 posedges after the second release; rd_data=0 and rd_valid=0 immediately on reset assertion.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the byte-enable simple-dual-port RAM
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  typedef enum bit {
    RD_FIRST = 1'b0,
    WR_FIRST = 1'b1
  } rdw_mode_e;

  function automatic int nbytes(input int data_wide, input int byte_wide);
    return data_wide / byte_wide;
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// rtl/ram_clr_fsm.sv - post-reset clear sweep; drives zero writes until every word is cleared
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int DEEP      = 512,
  parameter int ADDR_WIDE = $clog2(DEEP),
  parameter int INIT_CLR  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 clr_we,
  output logic [ADDR_WIDE-1:0] clr_addr,
  output logic                 init_done
);

  localparam logic [ADDR_WIDE-1:0] LAST_ADDR = ADDR_WIDE'(DEEP - 1);
  localparam ram_state_e RST_STATE = (INIT_CLR != 0) ? CLEAR : READY;
  localparam logic RST_DONE = (INIT_CLR != 0) ? 1'b0 : 1'b1;

  ram_state_e           state_q, state_d;
  logic [ADDR_WIDE-1:0] clr_cnt_q, clr_cnt_d;
  logic                 init_done_q, init_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= RST_DONE;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        // The edge that zeroes the last word is the one that hands over to READY.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  assign clr_addr  = clr_cnt_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple-dual-port RAM with byte enables, 1/2-cycle read latency, RDW select
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDE = 32,
  parameter int BYTE_WIDE = 8,
  parameter int DEEP      = 512,
  parameter int ADDR_WIDE = $clog2(DEEP),
  parameter int RD_LAT    = 1,
  parameter int RDW_MODE  = 0,
  parameter int INIT_CLR  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDE-1:0]           wr_addr,
  input  logic [DATA_WIDE/BYTE_WIDE-1:0] wr_be,
  input  logic [DATA_WIDE-1:0]           wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDE-1:0]           rd_addr,
  output logic [DATA_WIDE-1:0]           rd_data,
  output logic                           rd_valid,
  output logic                           oor_err,
  output logic                           init_done
);

  localparam int NB = nbytes(DATA_WIDE, BYTE_WIDE);
  localparam logic [ADDR_WIDE:0] DEPTH_L = (ADDR_WIDE + 1)'(DEEP);
  localparam rdw_mode_e MODE = (RDW_MODE == 1) ? WR_FIRST : RD_FIRST;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("ram_sdp_be: RD_LAT must be 1 or 2");
  end
  if (DATA_WIDE % BYTE_WIDE != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDE must be a multiple of BYTE_WIDE");
  end

  logic [DATA_WIDE-1:0] mem [DEEP];

  logic                 clr_we;
  logic [ADDR_WIDE-1:0] clr_addr;

  ram_clr_fsm #(
    .DEEP      (DEEP),
    .ADDR_WIDE (ADDR_WIDE),
    .INIT_CLR  (INIT_CLR)
  ) u_clr_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  logic                 wr_in_range, rd_in_range;
  logic                 wr_ok, rd_fire;
  logic                 mem_we;
  logic [ADDR_WIDE-1:0] mem_waddr, rd_idx;
  logic [NB-1:0]        mem_wbe;
  logic [DATA_WIDE-1:0] mem_wdata, rd_word, rd_new;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    wr_ok       = init_done & wr_en & wr_in_range;
    rd_fire     = init_done & rd_en;

    // Clear sweep owns the write port until init_done; user writes are then gated off.
    mem_we    = clr_we | wr_ok;
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wbe   = clr_we ? {NB{1'b1}} : wr_be;
    mem_wdata = clr_we ? '0 : wr_data;

    rd_idx  = rd_in_range ? rd_addr : '0;
    rd_word = mem[rd_idx];
    if (MODE == WR_FIRST && wr_ok && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDE +: BYTE_WIDE] = wr_data[i*BYTE_WIDE +: BYTE_WIDE];
        end
      end
    end
    rd_new = rd_in_range ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_waddr][i*BYTE_WIDE +: BYTE_WIDE] <= mem_wdata[i*BYTE_WIDE +: BYTE_WIDE];
        end
      end
    end
  end

  logic [DATA_WIDE-1:0] rd1_data_q, rd1_data_d;
  logic                 rd1_valid_q, rd1_valid_d;
  logic                 rd1_oor_q, rd1_oor_d;
  logic                 wr_oor_q, wr_oor_d;

  always_comb begin
    rd1_valid_d = rd_fire;
    rd1_oor_d   = rd_fire & ~rd_in_range;
    rd1_data_d  = rd_fire ? rd_new : rd1_data_q;
    wr_oor_d    = init_done & wr_en & ~wr_in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
      rd1_oor_q   <= 1'b0;
      wr_oor_q    <= 1'b0;
    end else begin
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
      rd1_oor_q   <= rd1_oor_d;
      wr_oor_q    <= wr_oor_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_WIDE-1:0] rd2_data_q, rd2_data_d;
    logic                 rd2_valid_q, rd2_valid_d;
    logic                 rd2_oor_q, rd2_oor_d;

    always_comb begin
      rd2_valid_d = rd1_valid_q;
      rd2_oor_d   = rd1_oor_q;
      rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd2_data_q  <= '0;
        rd2_valid_q <= 1'b0;
        rd2_oor_q   <= 1'b0;
      end else begin
        rd2_data_q  <= rd2_data_d;
        rd2_valid_q <= rd2_valid_d;
        rd2_oor_q   <= rd2_oor_d;
      end
    end

    assign rd_data  = rd2_data_q;
    assign rd_valid = rd2_valid_q;
    // Write-side and read-side errors land in different cycles here, so two pulses appear.
    assign oor_err  = wr_oor_q | rd2_oor_q;
  end else begin : g_lat1
    assign rd_data  = rd1_data_q;
    assign rd_valid = rd1_valid_q;
    assign oor_err  = wr_oor_q | rd1_oor_q;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - directed self-checking bench for ram_sdp_be across latency/RDW/depth variants
module tb_ram_sdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [8:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic [31:0] a_rd_data, b_rd_data, c_rd_data;
  logic        a_rd_valid, b_rd_valid, c_rd_valid;
  logic        a_oor, b_oor, c_oor;
  logic        a_init_done, b_init_done, c_init_done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // a: RD_LAT=1 read-first, b: RD_LAT=2 write-first, c: DEEP=500 RD_LAT=1 read-first
  ram_sdp_be #(.DATA_WIDE(32), .BYTE_WIDE(8), .DEEP(512), .RD_LAT(1), .RDW_MODE(0), .INIT_CLR(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .oor_err(a_oor),
    .init_done(a_init_done));

  ram_sdp_be #(.DATA_WIDE(32), .BYTE_WIDE(8), .DEEP(512), .RD_LAT(2), .RDW_MODE(1), .INIT_CLR(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .oor_err(b_oor),
    .init_done(b_init_done));

  ram_sdp_be #(.DATA_WIDE(32), .BYTE_WIDE(8), .DEEP(500), .RD_LAT(1), .RDW_MODE(0), .INIT_CLR(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .oor_err(c_oor),
    .init_done(c_init_done));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if ({a_rd_data, b_rd_data, c_rd_data} !== 96'h0) $display("FAIL reset_rd_data: got %h/%h/%h expected 0", a_rd_data, b_rd_data, c_rd_data); else passes++;
    checks++; if ({a_rd_valid, b_rd_valid, c_rd_valid, a_oor, b_oor, c_oor} !== 6'b0) $display("FAIL reset_valid_oor: got %b expected 000000", {a_rd_valid, b_rd_valid, c_rd_valid, a_oor, b_oor, c_oor}); else passes++;
    checks++; if ({a_init_done, b_init_done, c_init_done} !== 3'b000) $display("FAIL reset_init_done: got %b expected 000", {a_init_done, b_init_done, c_init_done}); else passes++;
  endtask

  task automatic test_clear_sweep;
    int n = 0;
    int nc = 0;
    logic seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 9'd5;
    while (!a_init_done && n < 1000) begin
      tick();
      n++;
      if (n <= 300 && (a_rd_valid | b_rd_valid | c_rd_valid | a_oor | b_oor | c_oor)) seen = 1'b1;
      if (n == 300) idle();
      if (c_init_done && nc == 0) nc = n;
    end
    idle();
    checks++; if (n !== 512) $display("FAIL init_edges_512: got %0d expected 512", n); else passes++;
    checks++; if (nc !== 500) $display("FAIL init_edges_500: got %0d expected 500", nc); else passes++;
    checks++; if (seen !== 1'b0) $display("FAIL clear_ignores_req: got %b expected 0", seen); else passes++;
    checks++; if (b_init_done !== 1'b1) $display("FAIL b_init_done: got %b expected 1", b_init_done); else passes++;
    rd_en = 1'b1; rd_addr = 9'd5;
    tick();
    idle();
    checks++; if ({a_rd_valid, a_rd_data} !== {1'b1, 32'h0}) $display("FAIL clear_read_a: got %b/%h expected 1/00000000", a_rd_valid, a_rd_data); else passes++;
    tick();
    checks++; if ({b_rd_valid, b_rd_data} !== {1'b1, 32'h0}) $display("FAIL clear_read_b: got %b/%h expected 1/00000000", b_rd_valid, b_rd_data); else passes++;
  endtask

  task automatic test_byte_enable;
    wr_en = 1'b1; wr_addr = 9'd132; wr_data = 32'h11223344; wr_be = 4'hF;
    tick();
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 9'd132;
    tick();
    idle();
    checks++; if ({a_rd_valid, a_rd_data} !== {1'b1, 32'h11BB33DD}) $display("FAIL be_lat1: got %b/%h expected 1/11bb33dd", a_rd_valid, a_rd_data); else passes++;
    checks++; if (b_rd_valid !== 1'b0) $display("FAIL be_lat2_early: got %b expected 0", b_rd_valid); else passes++;
    tick();
    checks++; if (a_rd_valid !== 1'b0) $display("FAIL be_lat1_pulse: got %b expected 0", a_rd_valid); else passes++;
    checks++; if ({b_rd_valid, b_rd_data} !== {1'b1, 32'h11BB33DD}) $display("FAIL be_lat2: got %b/%h expected 1/11bb33dd", b_rd_valid, b_rd_data); else passes++;
    checks++; if (a_rd_data !== 32'h11BB33DD) $display("FAIL hold_rd_data: got %h expected 11bb33dd", a_rd_data); else passes++;
  endtask

  task automatic test_collision;
    wr_en = 1'b1; wr_addr = 9'd133; wr_data = 32'h00000001; wr_be = 4'hF;
    tick();
    wr_data = 32'h55555555; rd_en = 1'b1; rd_addr = 9'd133;
    tick();
    idle();
    checks++; if ({a_rd_valid, a_rd_data} !== {1'b1, 32'h00000001}) $display("FAIL rdw_read_first: got %b/%h expected 1/00000001", a_rd_valid, a_rd_data); else passes++;
    tick();
    checks++; if ({b_rd_valid, b_rd_data} !== {1'b1, 32'h55555555}) $display("FAIL rdw_write_first: got %b/%h expected 1/55555555", b_rd_valid, b_rd_data); else passes++;
    rd_en = 1'b1; rd_addr = 9'd133;
    tick();
    idle();
    checks++; if (a_rd_data !== 32'h55555555) $display("FAIL rdw_after_a: got %h expected 55555555", a_rd_data); else passes++;
    tick();
    checks++; if (b_rd_data !== 32'h55555555) $display("FAIL rdw_after_b: got %h expected 55555555", b_rd_data); else passes++;
  endtask

  task automatic test_out_of_range;
    rd_en = 1'b1; rd_addr = 9'd511;
    tick();
    idle();
    checks++; if ({c_rd_valid, c_oor, c_rd_data} !== {2'b11, 32'h0}) $display("FAIL oor_read_c: got %b/%b/%h expected 1/1/00000000", c_rd_valid, c_oor, c_rd_data); else passes++;
    checks++; if ({a_rd_valid, a_oor} !== 2'b10) $display("FAIL inrange_read_a: got %b/%b expected 1/0", a_rd_valid, a_oor); else passes++;
    tick();
    checks++; if (c_oor !== 1'b0) $display("FAIL oor_read_pulse: got %b expected 0", c_oor); else passes++;
    wr_en = 1'b1; wr_addr = 9'd510; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    tick();
    idle();
    checks++; if ({c_oor, a_oor} !== 2'b10) $display("FAIL oor_write: got c=%b a=%b expected c=1 a=0", c_oor, a_oor); else passes++;
    tick();
    checks++; if (c_oor !== 1'b0) $display("FAIL oor_write_pulse: got %b expected 0", c_oor); else passes++;
    wr_en = 1'b1; wr_addr = 9'd510; rd_en = 1'b1; rd_addr = 9'd511;
    tick();
    idle();
    checks++; if ({c_oor, c_rd_valid} !== 2'b11) $display("FAIL oor_both: got %b/%b expected 1/1", c_oor, c_rd_valid); else passes++;
    tick();
    checks++; if (c_oor !== 1'b0) $display("FAIL oor_both_merged: got %b expected 0", c_oor); else passes++;
    rd_en = 1'b1; rd_addr = 9'd10;
    tick();
    idle();
    checks++; if (c_rd_data !== 32'h0) $display("FAIL oor_no_alias: got %h expected 00000000", c_rd_data); else passes++;
    rd_en = 1'b1; rd_addr = 9'd510;
    tick();
    idle();
    checks++; if (a_rd_data !== 32'hFFFFFFFF) $display("FAIL inrange_write_a: got %h expected ffffffff", a_rd_data); else passes++;
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 9'(i); wr_data = 32'(i * 3); wr_be = 4'hF;
      tick();
    end
    idle();
    tick();
    for (int i = 0; i < 10; i++) begin
      rd_en = (i < 8); rd_addr = 9'(i);
      tick();
      if (i < 8) begin
        checks++; if ({a_rd_valid, a_rd_data} !== {1'b1, 32'(i * 3)}) $display("FAIL b2b_lat1[%0d]: got %b/%h expected 1/%h", i, a_rd_valid, a_rd_data, 32'(i * 3)); else passes++;
      end else begin
        checks++; if (a_rd_valid !== 1'b0) $display("FAIL b2b_lat1_end[%0d]: got %b expected 0", i, a_rd_valid); else passes++;
      end
      if (i >= 1 && i <= 8) begin
        checks++; if ({b_rd_valid, b_rd_data} !== {1'b1, 32'((i - 1) * 3)}) $display("FAIL b2b_lat2[%0d]: got %b/%h expected 1/%h", i, b_rd_valid, b_rd_data, 32'((i - 1) * 3)); else passes++;
      end else begin
        checks++; if (b_rd_valid !== 1'b0) $display("FAIL b2b_lat2_idle[%0d]: got %b expected 0", i, b_rd_valid); else passes++;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear;
    int n = 0;
    rd_en = 1'b1; rd_addr = 9'd7;
    tick();
    idle();
    checks++; if ({a_rd_valid, a_rd_data} !== {1'b1, 32'd21}) $display("FAIL pre_reset_read: got %b/%h expected 1/00000015", a_rd_valid, a_rd_data); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_rd_valid, a_rd_data, b_rd_data} !== {1'b0, 64'h0}) $display("FAIL async_reset: got %b/%h/%h expected 0/0/0", a_rd_valid, a_rd_data, b_rd_data); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) tick();
    checks++; if (a_init_done !== 1'b0) $display("FAIL mid_clear_busy: got %b expected 0", a_init_done); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (a_init_done !== 1'b0) $display("FAIL mid_clear_reset: got %b expected 0", a_init_done); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    while (!a_init_done && n < 1000) begin
      tick();
      n++;
    end
    checks++; if (n !== 512) $display("FAIL restart_edges: got %0d expected 512", n); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    #3;
    test_reset();
    test_clear_sweep();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
